librelane3_test_rename4: RTL and testbench



---
 rtl/librelane3_test_rename4_pkg.sv | 17 +
 rtl/rename4_counter.sv | 31 +++
 rtl/librelane3_test_rename4.sv | 61 ++++++
 tb/tb_librelane3_test_rename4.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/librelane3_test_rename4_pkg.sv
// Shared constants for the librelane3_test_rename4 tile: counter width and
// the mode encodings taken from ui_in[7:6].
package librelane3_test_rename4_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] MODE_LOOP  = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CMP   = 2'b11;

  // COUNT and COMPARE both advance the counter
  function automatic logic is_step_mode(input logic [1:0] mode);
    return (mode == MODE_COUNT) || (mode == MODE_CMP);
  endfunction

endpackage

// File: rtl/rename4_counter.sv
// 8-bit modulo-256 up/down counter with asynchronous active-low reset,
// synchronous load (priority over stepping) and a direction-aware terminal flag.
module rename4_counter
  import librelane3_test_rename4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en) begin
      r_cnt <= dir ? (r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
    end
  end

  assign cnt  = r_cnt;
  assign term = dir ? (r_cnt == '0) : (r_cnt == '1);

endmodule

// File: rtl/librelane3_test_rename4.sv
// Tiny Tapeout bring-up tile: up/down counter with loopback, count, load and
// compare modes selected by ui_in[7:6]; outputs are a combinational mode decode.
module librelane3_test_rename4
  import librelane3_test_rename4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0]       w_mode;
  logic             w_step;
  logic             w_load;
  logic [CNT_W-1:0] w_cnt;
  logic             w_term;

  assign w_mode = ui_in[7:6];
  assign w_step = ena && ui_in[0] && is_step_mode(w_mode);
  assign w_load = ena && (w_mode == MODE_LOAD);

  rename4_counter u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_step),
    .dir      (ui_in[1]),
    .load     (w_load),
    .load_val (uio_in),
    .cnt      (w_cnt),
    .term     (w_term)
  );

  always_comb begin
    uo_out  = 8'h00;
    uio_out = 8'h00;
    uio_oe  = 8'h00;
    case (w_mode)
      MODE_LOOP: begin
        uo_out = ui_in;
      end
      MODE_COUNT: begin
        uo_out  = w_cnt;
        uio_out = w_cnt;
        uio_oe  = 8'hFF;
      end
      MODE_LOAD: begin
        uo_out = w_cnt;
      end
      default: begin
        uo_out[0] = (w_cnt == uio_in);
        uo_out[1] = (w_cnt > uio_in);
        uo_out[2] = w_term;
      end
    endcase
  end

endmodule

// File: tb/tb_librelane3_test_rename4.sv
// Self-checking bench for librelane3_test_rename4: directed scenarios followed
// by randomized stimulus compared against a behavioural model of the tile.
module tb_librelane3_test_rename4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  librelane3_test_rename4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs from the mode table, given a counter value and inputs
  task automatic model_outputs(input int cnt, input logic [7:0] ui, input logic [7:0] uio,
                               output logic [7:0] e_uo, output logic [7:0] e_uout,
                               output logic [7:0] e_oe);
    int mode;
    int opnd;
    mode   = ui / 64;
    opnd   = uio;
    e_uo   = 8'h00;
    e_uout = 8'h00;
    e_oe   = 8'h00;
    if (mode == 0) begin
      e_uo = ui;
    end else if (mode == 1) begin
      e_uo   = 8'(cnt);
      e_uout = 8'(cnt);
      e_oe   = 8'hFF;
    end else if (mode == 2) begin
      e_uo = 8'(cnt);
    end else begin
      if (cnt == opnd) e_uo = e_uo + 8'd1;
      if (cnt > opnd)  e_uo = e_uo + 8'd2;
      if ((ui[1] == 1'b0 && cnt == 255) || (ui[1] == 1'b1 && cnt == 0)) e_uo = e_uo + 8'd4;
    end
  endtask

  function automatic int model_next(input int cnt, input logic en, input logic [7:0] ui,
                                    input logic [7:0] uio);
    int mode;
    mode = ui / 64;
    if (!en) return cnt;
    if (mode == 2) return uio;
    if ((mode == 1 || mode == 3) && ui[0]) return ui[1] ? (cnt + 255) % 256 : (cnt + 1) % 256;
    return cnt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [7:0] v);
    @(negedge clk);
    ui_in  = 8'h80;
    uio_in = v;
    ena    = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] e_uo, e_uout, e_oe;

    // 1: reset held, COUNT mode
    ui_in = 8'h41;
    ena   = 1'b1;
    #12;
    check_val("rst_uo", uo_out, 8'h00);
    check_val("rst_oe", uio_oe, 8'hFF);
    check_val("rst_uio_out", uio_out, 8'h00);

    // 2: count up 258 cycles with wrap
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 258; i++) begin
      tick();
      check_val("count_up", uo_out, 8'(i % 256));
    end
    check_val("count_up_uio_out", uio_out, 8'h02);

    // 3: load 05 then count down through the wrap
    load_value(8'h05);
    check_val("load_05", uo_out, 8'h05);
    check_val("load_oe", uio_oe, 8'h00);
    @(negedge clk);
    ui_in = 8'h43;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_val("count_down", uo_out, 8'((5 - i + 256) % 256));
    end

    // 4: compare against loaded 3C with counting disabled
    load_value(8'h3C);
    @(negedge clk);
    ui_in  = 8'hC0;
    uio_in = 8'h3C;
    #1 check_val("cmp_eq", uo_out, 8'h01);
    uio_in = 8'h10;
    #1 check_val("cmp_gt", uo_out, 8'h02);
    uio_in = 8'h50;
    #1 check_val("cmp_lt", uo_out, 8'h00);
    check_val("cmp_oe", uio_oe, 8'h00);

    // 5: loopback, then ena=0 freeze in COUNT mode
    ui_in = 8'h2A;
    #1 check_val("loop_uo", uo_out, 8'h2A);
    check_val("loop_oe", uio_oe, 8'h00);
    ui_in = 8'h41;
    ena   = 1'b0;
    repeat (5) tick();
    check_val("ena_hold", uo_out, 8'h3C);

    // 6: async reset between edges while counting
    @(negedge clk);
    ena = 1'b1;
    tick();
    check_val("pre_async", uo_out, 8'h3D);
    #2 rst_n = 1'b0;
    #1 check_val("async_rst", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("resume_from_0", uo_out, 8'h01);

    // Randomized stimulus against the model
    m_cnt = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ui_in  = 8'($urandom);
      uio_in = ($urandom_range(0, 3) == 0) ? 8'(m_cnt) : 8'($urandom);
      ena    = ($urandom_range(0, 7) != 0);
      rst_n  = ($urandom_range(0, 63) != 0);
      if (!rst_n) m_cnt = 0;
      #1;
      model_outputs(m_cnt, ui_in, uio_in, e_uo, e_uout, e_oe);
      check_val("rnd_uo", uo_out, e_uo);
      check_val("rnd_uio_out", uio_out, e_uout);
      check_val("rnd_oe", uio_oe, e_oe);
      @(posedge clk);
      if (rst_n) m_cnt = model_next(m_cnt, ena, ui_in, uio_in);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
